// File: rtl/adder_rr_arbiter.sv
//==============================================================================
// Module   : adder_rr_arbiter
// Purpose  : Round-robin sequencer sharing one external combinational adder
//            among NREQ requesters; results are returned tagged with the
//            requester id. Optional macro ADDER_ARB_PIPE_EN overlaps the
//            response handshake with the next grant.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module adder_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 7,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid_i,
    output logic [NREQ-1:0]   req_ready_o,
    input  logic [NREQ*W-1:0] req_a_i,
    input  logic [NREQ*W-1:0] req_b_i,
    input  logic [NREQ-1:0]   req_cin_i,
    output logic [W-1:0]      add_a_o,
    output logic [W-1:0]      add_b_o,
    output logic              add_cin_o,
    input  logic [W:0]        add_sum_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [IDW-1:0]    rsp_id_o,
    output logic [W:0]        rsp_sum_o
);

    localparam int PW = IDW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state_q;
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  ptr_d;
    logic [W-1:0]    add_a_q;
    logic [W-1:0]    add_b_q;
    logic            add_cin_q;
    logic            rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [W:0]      rsp_sum_q;

    logic            gnt_found;
    logic [IDW-1:0]  gnt_idx;
    logic [PW-1:0]   scan_pos;
    logic            arb_en;
    logic            accept;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;
    logic            sel_cin;

    // Scan ptr, ptr+1, ... wrapping modulo NREQ; first valid requester wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_pos  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_pos = {1'b0, ptr_q} + PW'(k);
            if (scan_pos >= PW'(NREQ)) begin
                scan_pos = scan_pos - PW'(NREQ);
            end
            if (!gnt_found && req_valid_i[scan_pos[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_pos[IDW-1:0];
            end
        end
    end

    assign ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);

`ifdef ADDER_ARB_PIPE_EN
    assign arb_en = (state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready_i);
`else
    assign arb_en = (state_q == S_IDLE);
`endif

    assign accept  = arb_en && gnt_found;
    assign sel_a   = req_a_i[int'(gnt_idx) * W +: W];
    assign sel_b   = req_b_i[int'(gnt_idx) * W +: W];
    assign sel_cin = req_cin_i[gnt_idx];

    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_ready
            assign req_ready_o[i] = accept && (gnt_idx == IDW'(i));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: ;
                S_EXEC: begin
                    rsp_sum_q   <= add_sum_i;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            // Accept only fires in IDLE or (pipelined) completing RESP, so it overrides the above.
            if (accept) begin
                add_a_q   <= sel_a;
                add_b_q   <= sel_b;
                add_cin_q <= sel_cin;
                rsp_id_q  <= gnt_idx;
                ptr_q     <= ptr_d;
                state_q   <= S_EXEC;
            end
        end
    end

    assign add_a_o     = add_a_q;
    assign add_b_o     = add_b_q;
    assign add_cin_o   = add_cin_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_sum_o   = rsp_sum_q;

endmodule

`default_nettype wire

// File: tb/tb_adder_rr_arbiter.sv
//==============================================================================
// Module   : tb_adder_rr_arbiter
// Purpose  : Directed self-checking bench for adder_rr_arbiter with a
//            behavioural shared adder. Honours ADDER_ARB_PIPE_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_adder_rr_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 7;
    localparam int IDW  = 2;
`ifdef ADDER_ARB_PIPE_EN
    localparam int GAP = 2;
`else
    localparam int GAP = 3;
`endif

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic [W-1:0]      add_a;
    logic [W-1:0]      add_b;
    logic              add_cin;
    logic [W:0]        add_sum;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W:0]        rsp_sum;

    int n_total;
    int n_bad;
    int cyc;

    adder_rr_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_cin_i   (req_cin),
        .add_a_o     (add_a),
        .add_b_o     (add_b),
        .add_cin_o   (add_cin),
        .add_sum_i   (add_sum),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .rsp_sum_o   (rsp_sum)
    );

    assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c);
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_cin[id]      = c;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0;
        step();
        n_total++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_sum !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_rsp: valid=%b id=%0d sum=%h want 0/0/00", rsp_valid, rsp_id, rsp_sum);
        end
        n_total++;
        if ({add_a, add_b, add_cin} !== 15'd0) begin
            n_bad++;
            $display("FAIL reset_add: a=%h b=%h cin=%b want all 0", add_a, add_b, add_cin);
        end
        n_total++;
        if (req_ready !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_single();
        set_op(0, 7'h7F, 7'h01, 1'b0);
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        #1;
        n_total++;
        if (req_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL single_ready: got %b want 0001", req_ready);
        end
        step();
        req_valid = 4'b0000;
        #1;
        n_total++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
            n_bad++;
            $display("FAIL single_exec: valid=%b ready=%b want 0/0000", rsp_valid, req_ready);
        end
        n_total++;
        if ({add_a, add_b, add_cin} !== {7'h7F, 7'h01, 1'b0}) begin
            n_bad++;
            $display("FAIL single_add: a=%h b=%h cin=%b want 7f/01/0", add_a, add_b, add_cin);
        end
        step();
        n_total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 8'h80) begin
            n_bad++;
            $display("FAIL single_rsp: valid=%b id=%0d sum=%h want 1/0/80", rsp_valid, rsp_id, rsp_sum);
        end
        rsp_ready = 1'b1;
        step();
        n_total++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_done: valid=%b want 0", rsp_valid);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_round_robin();
        int         exp_id [5];
        logic [W:0] exp_sum [NREQ];
        int         last;
        int         waited;
        exp_id = '{0, 1, 2, 3, 0};
        exp_sum[0] = 8'h30;
        exp_sum[1] = 8'hFF;
        exp_sum[2] = 8'h80;
        exp_sum[3] = 8'h04;
        apply_reset();
        set_op(0, 7'h10, 7'h20, 1'b0);
        set_op(1, 7'h7F, 7'h7F, 1'b1);
        set_op(2, 7'h40, 7'h40, 1'b0);
        set_op(3, 7'h01, 7'h02, 1'b1);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        last = -1;
        for (int t = 0; t < 5; t++) begin
            waited = 0;
            while (req_ready === 4'b0000 && waited < 8) begin
                step();
                waited++;
            end
            n_total++;
            if (req_ready !== (4'b0001 << exp_id[t])) begin
                n_bad++;
                $display("FAIL rr_grant[%0d]: got %b want id %0d", t, req_ready, exp_id[t]);
            end
            if (last >= 0) begin
                n_total++;
                if (cyc - last != GAP) begin
                    n_bad++;
                    $display("FAIL rr_gap[%0d]: got %0d want %0d", t, cyc - last, GAP);
                end
            end
            last = cyc;
            step();
            step();
            n_total++;
            if (rsp_valid !== 1'b1 || rsp_id !== exp_id[t][IDW-1:0]) begin
                n_bad++;
                $display("FAIL rr_rsp[%0d]: valid=%b id=%0d want 1/%0d", t, rsp_valid, rsp_id, exp_id[t]);
            end
            n_total++;
            if (rsp_sum !== exp_sum[exp_id[t]]) begin
                n_bad++;
                $display("FAIL rr_sum[%0d]: got %h want %h", t, rsp_sum, exp_sum[exp_id[t]]);
            end
        end
        req_valid = 4'b0000;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_ptr_wrap();
        set_op(3, 7'h55, 7'h2A, 1'b1);
        req_valid = 4'b1000;
        #1;
        n_total++;
        if (req_ready !== 4'b1000) begin
            n_bad++;
            $display("FAIL wrap_grant: got %b want 1000", req_ready);
        end
        step();
        req_valid = 4'b0000;
        step();
        n_total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_sum !== 8'h80) begin
            n_bad++;
            $display("FAIL wrap_rsp: valid=%b id=%0d sum=%h want 1/3/80", rsp_valid, rsp_id, rsp_sum);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        #1;
        n_total++;
        if (req_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL wrap_ptr: got %b want 0001", req_ready);
        end
        req_valid = 4'b0000;
        #1;
    endtask

    task automatic test_hold();
        set_op(0, 7'h33, 7'h44, 1'b0);
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        #1;
        step();
        req_valid = 4'b1111;
        step();
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 8'h77) begin
                n_bad++;
                $display("FAIL hold_rsp[%0d]: valid=%b id=%0d sum=%h want 1/0/77", i, rsp_valid, rsp_id, rsp_sum);
            end
            n_total++;
            if (req_ready !== 4'b0000) begin
                n_bad++;
                $display("FAIL hold_ready[%0d]: got %b want 0000", i, req_ready);
            end
            step();
        end
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        step();
        n_total++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_done: valid=%b want 0", rsp_valid);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic seen;
        set_op(2, 7'h12, 7'h34, 1'b1);
        req_valid = 4'b0100;
        #1;
        n_total++;
        if (req_ready !== 4'b0100) begin
            n_bad++;
            $display("FAIL mid_grant: got %b want 0100", req_ready);
        end
        step();
        n_total++;
        if ({add_a, add_b, add_cin} !== {7'h12, 7'h34, 1'b1}) begin
            n_bad++;
            $display("FAIL mid_add: a=%h b=%h cin=%b want 12/34/1", add_a, add_b, add_cin);
        end
        rst_n = 1'b0;
        req_valid = 4'b0000;
        #1;
        n_total++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_sum !== 8'h00 ||
            {add_a, add_b, add_cin} !== 15'd0 || req_ready !== 4'b0000) begin
            n_bad++;
            $display("FAIL mid_clear: valid=%b id=%0d sum=%h a=%h b=%h cin=%b ready=%b want all 0",
                     rsp_valid, rsp_id, rsp_sum, add_a, add_b, add_cin, req_ready);
        end
        step();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (rsp_valid !== 1'b0) seen = 1'b1;
        end
        n_total++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_dropped: rsp_valid seen=%b want 0", seen);
        end
        req_valid = 4'b1111;
        #1;
        n_total++;
        if (req_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL mid_ptr: got %b want 0001", req_ready);
        end
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        #1;
    endtask

    task automatic test_throughput();
        int         exp_id [4];
        logic [W:0] exp_sum [2];
        int         last;
        int         waited;
        exp_id = '{0, 1, 0, 1};
        exp_sum[0] = 8'h0B;
        exp_sum[1] = 8'h16;
        apply_reset();
        set_op(0, 7'h05, 7'h06, 1'b0);
        set_op(1, 7'h0A, 7'h0B, 1'b1);
        req_valid = 4'b0011;
        rsp_ready = 1'b1;
        #1;
        last = -1;
        for (int t = 0; t < 4; t++) begin
            waited = 0;
            while (req_ready === 4'b0000 && waited < 8) begin
                step();
                waited++;
            end
            n_total++;
            if (req_ready !== (4'b0001 << exp_id[t])) begin
                n_bad++;
                $display("FAIL tp_grant[%0d]: got %b want id %0d", t, req_ready, exp_id[t]);
            end
            if (last >= 0) begin
                n_total++;
                if (cyc - last != GAP) begin
                    n_bad++;
                    $display("FAIL tp_gap[%0d]: got %0d want %0d", t, cyc - last, GAP);
                end
            end
            last = cyc;
            step();
            step();
            n_total++;
            if (rsp_valid !== 1'b1 || rsp_sum !== exp_sum[exp_id[t]]) begin
                n_bad++;
                $display("FAIL tp_rsp[%0d]: valid=%b sum=%h want 1/%h", t, rsp_valid, rsp_sum, exp_sum[exp_id[t]]);
            end
        end
        req_valid = 4'b0000;
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        cyc       = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_ptr_wrap();
        test_hold();
        test_reset_mid();
        test_throughput();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

`default_nettype wire
